// File: rtl/if_fetch_aligner.sv
// if_fetch_aligner: IF stage word fetcher and instruction realigner.
// Fetches aligned 32-bit words with at most one request outstanding and hands whole
// instructions to a registered IF/ID slot. A 32-bit instruction may straddle a word boundary.
// Build option: define RVC_EN for RV32IC halfword alignment. Without it, each fetched word
// is emitted as one 32-bit instruction.
module if_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o,
    output logic        id_is_c_o
);

    typedef enum logic [1:0] {
        StFetch   = 2'd0,
        StWait    = 2'd1,
        StDiscard = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic        rbuf_valid_q, rbuf_valid_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_is_c_q, id_is_c_d;

    logic        resp_take;
    logic        word_valid;
    logic [31:0] word;
    logic        word_free;
    logic        can_load;
    logic        emit;
    logic        emit_is_c;
    logic [31:0] emit_instr;
    logic [31:0] align_pc_d;
    logic [31:0] redirect_pc;
    logic [31:0] redirect_addr;
    logic        unused_redirect_lsb;

    // A response is only taken in WAIT; a redirect in the same cycle drops it.
    assign resp_take  = (state_q == StWait) && imem_rvalid_i && !redirect_i;
    // The aligner sees the buffered word, or the word arriving this cycle. rbuf is
    // always empty in WAIT, so the two never compete.
    assign word_valid = rbuf_valid_q || resp_take;
    assign word       = rbuf_valid_q ? rbuf_q : imem_rdata_i;
    assign can_load   = !id_valid_q || id_ready_i;

`ifdef RVC_EN
    assign redirect_pc         = {redirect_pc_i[31:1], 1'b0};
    assign unused_redirect_lsb = redirect_pc_i[0];
`else
    assign redirect_pc         = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];
`endif
    assign redirect_addr = {redirect_pc_i[31:2], 2'b00};

`ifdef RVC_EN
    // The stash holds the upper halfword of an older word. It is only valid when
    // pc[1]=1, and it is then the halfword at pc.
    logic [15:0] stash_q, stash_d;
    logic        stash_valid_q, stash_valid_d, stash_valid_align;
    logic [15:0] half;

    // Pick the halfword at pc and decide what this cycle emits, stashes or frees.
    always_comb begin
        emit              = 1'b0;
        emit_instr        = '0;
        emit_is_c         = 1'b0;
        align_pc_d        = pc_q;
        word_free         = 1'b0;
        stash_d           = stash_q;
        stash_valid_align = stash_valid_q;
        half              = stash_valid_q ? stash_q : (pc_q[1] ? word[31:16] : word[15:0]);
        if (can_load && (stash_valid_q || word_valid)) begin
            if (half[1:0] != 2'b11) begin
                emit       = 1'b1;
                emit_instr = {16'h0000, half};
                emit_is_c  = 1'b1;
                align_pc_d = pc_q + 32'd2;
                if (stash_valid_q) begin
                    stash_valid_align = 1'b0;
                end else if (pc_q[1]) begin
                    word_free = 1'b1;
                end
            end else if (stash_valid_q) begin
                // Straddling instruction: the stash supplies the low half, and the
                // new word's upper half becomes the next stash.
                if (word_valid) begin
                    emit       = 1'b1;
                    emit_instr = {word[15:0], stash_q};
                    align_pc_d = pc_q + 32'd4;
                    stash_d    = word[31:16];
                    word_free  = 1'b1;
                end
            end else if (!pc_q[1]) begin
                emit       = 1'b1;
                emit_instr = word;
                align_pc_d = pc_q + 32'd4;
                word_free  = 1'b1;
            end else begin
                stash_d           = word[31:16];
                stash_valid_align = 1'b1;
                word_free         = 1'b1;
            end
        end
    end

    assign stash_valid_d = stash_valid_align && !redirect_i;

    // Stash register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stash_q       <= '0;
            stash_valid_q <= 1'b0;
        end else begin
            stash_q       <= stash_d;
            stash_valid_q <= stash_valid_d;
        end
    end
`else
    // Each word is exactly one instruction.
    always_comb begin
        emit       = 1'b0;
        emit_instr = '0;
        emit_is_c  = 1'b0;
        align_pc_d = pc_q;
        word_free  = 1'b0;
        if (can_load && word_valid) begin
            emit       = 1'b1;
            emit_instr = word;
            align_pc_d = pc_q + 32'd4;
            word_free  = 1'b1;
        end
    end
`endif

    // Fetch FSM, rbuf and pc next state; a redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        pc_d         = align_pc_d;
        rbuf_d       = word;
        rbuf_valid_d = word_valid && !word_free;
        case (state_q)
            StFetch: begin
                if (req_q && imem_gnt_i) begin
                    state_d      = StWait;
                    fetch_addr_d = fetch_addr_q + 32'd4;
                end
            end
            StWait:    if (imem_rvalid_i) state_d = StFetch;
            StDiscard: if (imem_rvalid_i) state_d = StFetch;
            default:   state_d = StFetch;
        endcase
        if (redirect_i) begin
            pc_d         = redirect_pc;
            fetch_addr_d = redirect_addr;
            rbuf_valid_d = 1'b0;
            // Discard only while a response is still owed. That includes a grant
            // accepted in this same cycle.
            if (state_q != StFetch && imem_rvalid_i) begin
                state_d = StFetch;
            end else if (state_q != StFetch || (req_q && imem_gnt_i)) begin
                state_d = StDiscard;
            end else begin
                state_d = StFetch;
            end
        end
        req_d = (state_d == StFetch) && !rbuf_valid_d;
    end

    // IF/ID output slot: load when free or transferring, otherwise hold.
    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_is_c_d  = id_is_c_q;
        if (redirect_i) begin
            id_valid_d = 1'b0;
        end else if (can_load) begin
            id_valid_d = emit;
            if (emit) begin
                id_pc_d    = pc_q;
                id_instr_d = emit_instr;
                id_is_c_d  = emit_is_c;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StFetch;
            req_q        <= 1'b0;
            fetch_addr_q <= RESET_PC & 32'hFFFF_FFFC;
            pc_q         <= RESET_PC;
            rbuf_q       <= '0;
            rbuf_valid_q <= 1'b0;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_instr_q   <= '0;
            id_is_c_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
            rbuf_q       <= rbuf_d;
            rbuf_valid_q <= rbuf_valid_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            id_is_c_q    <= id_is_c_d;
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = fetch_addr_q;
    assign id_valid_o  = id_valid_q;
    assign id_pc_o     = id_pc_q;
    assign id_instr_o  = id_instr_q;
    assign id_is_c_o   = id_is_c_q;

endmodule

// File: tb/tb_if_fetch_aligner.sv
// Bench for if_fetch_aligner. It has a randomized memory responder, and a reference
// model that walks the instruction stream from a model pc. Directed cases pin the model
// to literal values.
`timescale 1ns/1ps
module tb_if_fetch_aligner;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FILL     = 32'h0010_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_is_c_o;

    if_fetch_aligner #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .id_valid_o   (id_valid_o),
        .id_ready_i   (id_ready_i),
        .id_pc_o      (id_pc_o),
        .id_instr_o   (id_instr_o),
        .id_is_c_o    (id_is_c_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [256];
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] gaddr_q [$];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        c;
    } xfer_t;
    xfer_t log_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

`ifdef RVC_EN
    function automatic logic [15:0] mem_half(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction
`endif

    // Reference: the instruction that starts at pc, and its length.
    function automatic void model_next(input logic [31:0] pc, output logic [31:0] instr,
                                       output logic c, output logic [31:0] len);
`ifdef RVC_EN
        logic [15:0] h0;
        h0 = mem_half(pc);
        if (h0[1:0] != 2'b11) begin
            instr = {16'h0000, h0};
            c     = 1'b1;
            len   = 32'd2;
        end else begin
            instr = {mem_half(pc + 32'd2), h0};
            c     = 1'b0;
            len   = 32'd4;
        end
`else
        instr = mem[pc[9:2]];
        c     = 1'b0;
        len   = 32'd4;
`endif
    endfunction

    function automatic logic [31:0] redirect_target(input logic [31:0] r);
`ifdef RVC_EN
        return {r[31:1], 1'b0};
`else
        return {r[31:2], 2'b00};
`endif
    endfunction

    // Memory responder: random grants, one response lat_min..lat_max cycles after a grant.
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    logic        req_seen;
    logic [31:0] addr_seen;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            pend          = 1'b0;
            req_seen      = 1'b0;
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end else begin
            if (req_seen && imem_gnt_i) begin
                check("one_outstanding", {31'b0, pend}, 32'd0);
                check("req_addr_aligned", {30'b0, addr_seen[1:0]}, 32'd0);
                gaddr_q.push_back(addr_seen);
                pend  = 1'b1;
                cnt   = $urandom_range(lat_max, lat_min) - 1;
                paddr = addr_seen;
            end
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem[paddr[9:2]];
                    pend          = 1'b0;
                end else begin
                    cnt--;
                end
            end
            req_seen   = imem_req_o;
            addr_seen  = imem_addr_o;
            imem_gnt_i = ($urandom_range(99, 0) < gnt_pct);
        end
    end

    // Compare process: every transfer against the model, plus hold and flush rules.
    logic [31:0] mpc;
    logic        prev_hold;
    logic        prev_redir;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        hold_c;
    int          idle;
    always @(negedge clk) begin
        logic [31:0] e_instr;
        logic        e_c;
        logic [31:0] e_len;
        if (!rst_n) begin
            mpc        = RESET_PC;
            prev_hold  = 1'b0;
            prev_redir = 1'b0;
            idle       = 0;
            check("rst_id_valid", {31'b0, id_valid_o}, 32'd0);
            check("rst_req", {31'b0, imem_req_o}, 32'd0);
        end else begin
            if (prev_redir) check("valid_after_redirect", {31'b0, id_valid_o}, 32'd0);
            if (prev_hold) begin
                check("hold_valid", {31'b0, id_valid_o}, 32'd1);
                check("hold_pc", id_pc_o, hold_pc);
                check("hold_instr", id_instr_o, hold_instr);
                check("hold_is_c", {31'b0, id_is_c_o}, {31'b0, hold_c});
            end
            if (id_valid_o && id_ready_i) begin
                model_next(mpc, e_instr, e_c, e_len);
                check("xfer_pc", id_pc_o, mpc);
                check("xfer_instr", id_instr_o, e_instr);
                check("xfer_is_c", {31'b0, id_is_c_o}, {31'b0, e_c});
                log_q.push_back('{pc: id_pc_o, instr: id_instr_o, c: id_is_c_o});
                mpc  = mpc + e_len;
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 400) begin
                n_tests++;
                n_fail++;
                $display("FAIL watchdog: got %0d idle cycles, expected at most 400", idle);
                idle = 0;
            end
            prev_hold  = id_valid_o && !id_ready_i && !redirect_i;
            hold_pc    = id_pc_o;
            hold_instr = id_instr_o;
            hold_c     = id_is_c_o;
            prev_redir = redirect_i;
            if (redirect_i) mpc = redirect_target(redirect_pc_i);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        id_ready_i    = 1'b1;
        step(2);
        log_q.delete();
        gaddr_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = FILL;
    endtask

    task automatic wait_log(input int n, input string name);
        int k;
        k = 0;
        while (log_q.size() < n && k < 200) begin
            step(1);
            k++;
        end
        check(name, {31'b0, log_q.size() >= n}, 32'd1);
    endtask

    task automatic check_log(input int i, input logic [31:0] pc, input logic [31:0] instr,
                             input logic c, input string name);
        if (log_q.size() <= i) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no transfer %0d, expected pc 0x%08h", name, i, pc);
        end else begin
            check({name, "_pc"}, log_q[i].pc, pc);
            check({name, "_instr"}, log_q[i].instr, instr);
            check({name, "_is_c"}, {31'b0, log_q[i].c}, {31'b0, c});
        end
    endtask

    task automatic check_gaddr(input int i, input logic [31:0] addr, input string name);
        int k;
        k = 0;
        while (gaddr_q.size() <= i && k < 200) begin
            step(1);
            k++;
        end
        if (gaddr_q.size() <= i) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no request %0d, expected addr 0x%08h", name, i, addr);
        end else begin
            check(name, gaddr_q[i], addr);
        end
    endtask

    initial begin
        int          k;
        int          n0;
        logic [31:0] pc0;
        logic [15:0] h;
        logic [31:0] w;

        // Reset values and the first request.
        do_reset();
        check("reset_req", {31'b0, imem_req_o}, 32'd0);
        check("reset_addr", imem_addr_o, 32'h0);
        check("reset_pc", id_pc_o, 32'h0);
        check("reset_instr", id_instr_o, 32'h0);
        check("reset_is_c", {31'b0, id_is_c_o}, 32'd0);
        mem[0] = 32'h00A0_0093;
        rst_n = 1'b1;
        step(1);
        check("first_req", {31'b0, imem_req_o}, 32'd1);
        check("first_addr", imem_addr_o, 32'h0);
        check("first_valid", {31'b0, id_valid_o}, 32'd0);
        wait_log(1, "word32_seen");
        check_log(0, 32'h0, 32'h00A0_0093, 1'b0, "word32");
        check_gaddr(0, 32'h0, "word32_req0");
        check_gaddr(1, 32'h4, "word32_req1");

        // Two compressed instructions from one word.
        do_reset();
        mem[0] = 32'h0505_4505;
        rst_n = 1'b1;
`ifdef RVC_EN
        wait_log(2, "two_c_seen");
        check_log(0, 32'h0, 32'h0000_4505, 1'b1, "two_c0");
        check_log(1, 32'h2, 32'h0000_0505, 1'b1, "two_c1");
`else
        wait_log(1, "noc_seen");
        check_log(0, 32'h0, 32'h0505_4505, 1'b0, "noc0");
`endif
        check_gaddr(1, 32'h4, "two_c_req1");

`ifdef RVC_EN
        // A 32-bit instruction straddling a word boundary.
        do_reset();
        mem[0] = 32'h0093_4505;
        mem[1] = 32'h4505_00A0;
        rst_n = 1'b1;
        wait_log(3, "straddle_seen");
        check_log(0, 32'h0, 32'h0000_4505, 1'b1, "straddle0");
        check_log(1, 32'h2, 32'h00A0_0093, 1'b0, "straddle1");
        check_log(2, 32'h6, 32'h0000_4505, 1'b1, "straddle2");
`endif

        // Redirect while a response is outstanding.
        do_reset();
        lat_min = 5;
        lat_max = 5;
        mem[0]    = 32'h1111_1111;
        mem[8'h40] = 32'h0093_4505;
        mem[8'h41] = 32'h4505_00A0;
        rst_n = 1'b1;
        k = 0;
        while (gaddr_q.size() < 1 && k < 50) begin
            step(1);
            k++;
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        step(1);
        redirect_i = 1'b0;
        wait_log(1, "redir_seen");
`ifdef RVC_EN
        check_log(0, 32'h102, 32'h00A0_0093, 1'b0, "redir");
`else
        check_log(0, 32'h100, 32'h0093_4505, 1'b0, "redir");
`endif
        check_gaddr(1, 32'h100, "redir_req");
        lat_min = 1;
        lat_max = 1;

        // Address wrap at the top of the space.
        do_reset();
        rst_n = 1'b1;
        step(1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step(1);
        redirect_i = 1'b0;
        wait_log(2, "wrap_seen");
        check_log(0, 32'hFFFF_FFFC, FILL, 1'b0, "wrap0");
        check_log(1, 32'h0, FILL, 1'b0, "wrap1");

        // Back-pressure: three stalled cycles with a valid output.
        do_reset();
        rst_n = 1'b1;
        k = 0;
        while (!id_valid_o && k < 50) begin
            step(1);
            k++;
        end
        id_ready_i = 1'b0;
        pc0        = id_pc_o;
        step(2);
        check("stall_no_req", {31'b0, imem_req_o}, 32'd0);
        check("stall_valid", {31'b0, id_valid_o}, 32'd1);
        check("stall_pc", id_pc_o, pc0);
        step(1);
        id_ready_i = 1'b1;
        n0 = log_q.size();
        wait_log(n0 + 2, "stall_resume");
        if (log_q.size() > n0) check("stall_resume_pc", log_q[n0].pc, pc0);

        // Randomized traffic, redirects and resets.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            w = '0;
            for (int j = 0; j < 2; j++) begin
                h = 16'($urandom);
                if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
                else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
                w = j == 0 ? {16'h0000, h} : {h, w[15:0]};
            end
            mem[i] = w;
        end
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc % 1000 == 0) begin
                gnt_pct = $urandom_range(100, 30);
                lat_max = $urandom_range(4, 1);
            end
            id_ready_i = ($urandom_range(99, 0) < 70);
            redirect_i = ($urandom_range(99, 0) < 3);
            case ($urandom_range(2, 0))
                0:       redirect_pc_i = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
                1:       redirect_pc_i = 32'($urandom_range(1023, 0));
                default: redirect_pc_i = $urandom;
            endcase
            if ($urandom_range(999, 0) < 2) begin
                rst_n      = 1'b0;
                redirect_i = 1'b0;
                step(2);
                rst_n = 1'b1;
            end
            step(1);
        end
        redirect_i = 1'b0;
        id_ready_i = 1'b1;
        step(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
